// File: rtl/clock_seg_scan.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS clock.
// Digits are snapshotted once per frame and blanked briefly after every digit change.
module clock_seg_scan #(
    parameter int CLK_HZ         = 27_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int GHOST_CYC      = 16,
    parameter int LZB            = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic       CP,
    input  logic       CR,
    input  logic [3:0] HourH,
    input  logic [3:0] HourL,
    input  logic [3:0] MinH,
    input  logic [3:0] MinL,
    input  logic [3:0] SecH,
    input  logic [3:0] SecL,
    input  logic [5:0] blink_mask,
    input  logic       blink_phase,
    input  logic       colon_on,
    output logic [7:0] seg,
    output logic [5:0] dig,
    output logic       frame_done
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW  = (GHOST_CYC > 0) ? $clog2(GHOST_CYC + 1) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [GW-1:0] GHOST_LD = GW'(GHOST_CYC);

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h40;
        endcase
    endfunction

    logic [PW-1:0]     presc_q, presc_d;
    logic [2:0]        idx_q, idx_d;
    logic [GW-1:0]     ghost_q, ghost_d;
    logic [5:0][3:0]   snap_q, snap_d;
    logic [7:0]        seg_q, seg_d;
    logic [5:0]        dig_q, dig_d;
    logic              fd_q, fd_d;

    logic              tick, wrap, dark, lz_blank, dp;
    logic [3:0]        cur;

    always_comb begin
        tick     = (presc_q == PRE_MAX);
        wrap     = tick && (idx_q == 3'd5);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        idx_d    = idx_q;
        if (wrap)
            idx_d = 3'd0;
        else if (tick)
            idx_d = idx_q + 3'd1;

        ghost_d = ghost_q;
        if (tick)
            ghost_d = GHOST_LD;
        else if (ghost_q != '0)
            ghost_d = ghost_q - 1'b1;

        snap_d = snap_q;
        if (wrap)
            snap_d = {SecL, SecH, MinL, MinH, HourL, HourH};

        // Output stage looks at the current index, so dig/seg trail idx by one clock
        cur      = snap_q[idx_q];
        dark     = (ghost_q != '0) || (blink_phase && blink_mask[idx_q]);
        lz_blank = (LZB != 0) && (idx_q == 3'd0) && (snap_q[0] == 4'd0);
        dp       = colon_on && ((idx_q == 3'd1) || (idx_q == 3'd3)) && !dark;
        seg_d    = dark ? 8'h00 : {dp, (lz_blank ? 7'h00 : seg7(cur))};
        dig_d    = 6'b000001 << idx_q;
        fd_d     = wrap;
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            ghost_q <= '0;
            snap_q  <= '0;
            seg_q   <= 8'h00;
            dig_q   <= 6'h00;
            fd_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            ghost_q <= ghost_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            fd_q    <= fd_d;
        end
    end

    assign seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dig        = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_clock_seg_scan.sv
// Bench for clock_seg_scan: expected outputs derived from the clock count since clear
// and a per-frame snapshot of the digit inputs.
module tb_clock_seg_scan;

    localparam int DIV = 6;
    localparam int G   = 1;
    localparam int FR  = 6 * DIV;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic [3:0] HourH = 0, HourL = 0, MinH = 0, MinL = 0, SecH = 0, SecL = 0;
    logic [5:0] blink_mask = 6'd0;
    logic       blink_phase = 1'b0;
    logic       colon_on = 1'b0;
    logic [7:0] seg;
    logic [5:0] dig;
    logic       frame_done;

    clock_seg_scan #(
        .CLK_HZ(60), .SCAN_HZ(10), .GHOST_CYC(G), .LZB(1),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .CP(CP), .CR(CR),
        .HourH(HourH), .HourL(HourL), .MinH(MinH), .MinL(MinL), .SecH(SecH), .SecL(SecL),
        .blink_mask(blink_mask), .blink_phase(blink_phase), .colon_on(colon_on),
        .seg(seg), .dig(dig), .frame_done(frame_done)
    );

    always #5 CP = ~CP;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         k        = 0;
    logic [3:0] m_snap [6] = '{default: 4'd0};
    logic [7:0] seen   [6] = '{default: 8'd0};
    logic       last_fd = 1'b0;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (v > 4'd9) ? 7'h40 : tbl[v];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: predict the registered outputs from k (clocks since clear), then compare.
    task automatic step(input logic cr);
        logic [7:0] es;
        logic [5:0] ed;
        logic       ef, dark, lz, dp;
        int         idx;
        logic [3:0] live [6];
        live = '{HourH, HourL, MinH, MinL, SecH, SecL};
        CR = cr;
        if (cr) begin
            es = 8'h00; ed = 6'h00; ef = 1'b0;
        end else begin
            idx  = (k / DIV) % 6;
            dark = ((k >= DIV) && ((k % DIV) < G)) || (blink_phase && blink_mask[idx]);
            lz   = (idx == 0) && (m_snap[0] == 4'd0);
            dp   = colon_on && (idx == 1 || idx == 3) && !dark;
            es   = dark ? 8'h00 : {dp, (lz ? 7'h00 : seg7(m_snap[idx]))};
            ed   = 6'(1 << idx);
            ef   = ((k + 1) % FR) == 0;
        end
        @(posedge CP);
        #1;
        if (cr) begin
            k = 0;
            m_snap = '{default: 4'd0};
        end else begin
            k++;
            if (ef) m_snap = live;
        end
        check_eq("seg", 32'(seg), 32'(es));
        check_eq("dig", 32'(dig), 32'(ed));
        check_eq("frame_done", 32'(frame_done), 32'(ef));
        last_fd = frame_done;
        for (int i = 0; i < 6; i++)
            if (dig == 6'(1 << i)) seen[i] = seg;
    endtask

    task automatic sync_fd();
        int n = 0;
        do begin
            step(1'b0);
            n++;
        end while (!last_fd && n < 2 * FR);
        check_eq("fd_reached", 32'(last_fd), 32'd1);
    endtask

    task automatic frame();
        seen = '{default: 8'd0};
        repeat (FR) step(1'b0);
    endtask

    task automatic set_time(input logic [3:0] a, b, c, d, e, f);
        HourH = a; HourL = b; MinH = c; MinL = d; SecH = e; SecL = f;
    endtask

    initial begin
        // Reset held three clocks, then the digit walk
        repeat (3) step(1'b1);
        check_eq("rst_seg", 32'(seg), 32'h00);
        check_eq("rst_fd", 32'(frame_done), 32'd0);
        step(1'b0);
        check_eq("post_rst_dig", 32'(dig), 32'b000001);
        check_eq("post_rst_seg", 32'(seg), 32'h00);
        repeat (6) step(1'b0);
        check_eq("walk_dig1", 32'(dig), 32'b000010);
        repeat (24) step(1'b0);
        check_eq("walk_dig5", 32'(dig), 32'b100000);

        // 23:59:58 applied before the wrap
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
        sync_fd();
        frame();
        check_eq("t2_d0", 32'(seen[0]), 32'h5B);
        check_eq("t2_d1", 32'(seen[1]), 32'h4F);
        check_eq("t2_d2", 32'(seen[2]), 32'h6D);
        check_eq("t2_d3", 32'(seen[3]), 32'h6F);
        check_eq("t2_d4", 32'(seen[4]), 32'h6D);
        check_eq("t2_d5", 32'(seen[5]), 32'h7F);

        // SecL changes mid-frame: no tearing
        seen = '{default: 8'd0};
        repeat (18) step(1'b0);
        SecL = 4'd9;
        repeat (18) step(1'b0);
        check_eq("tear_same_frame", 32'(seen[5]), 32'h7F);
        frame();
        check_eq("tear_next_frame", 32'(seen[5]), 32'h6F);

        // Leading-zero blanking and colon dots: 09:05:00
        set_time(4'd0, 4'd9, 4'd0, 4'd5, 4'd0, 4'd0);
        colon_on = 1'b1;
        sync_fd();
        frame();
        check_eq("lzb_d0", 32'(seen[0]), 32'h00);
        check_eq("colon_d1", 32'(seen[1]), 32'hEF);
        check_eq("plain_d2", 32'(seen[2]), 32'h3F);
        check_eq("colon_d3", 32'(seen[3]), 32'hED);

        // Blink on digits 0 and 1
        blink_mask  = 6'b000011;
        blink_phase = 1'b1;
        frame();
        check_eq("blink_d0", 32'(seen[0]), 32'h00);
        check_eq("blink_d1", 32'(seen[1]), 32'h00);
        check_eq("blink_d2", 32'(seen[2]), 32'h3F);
        blink_phase = 1'b0;
        frame();
        check_eq("unblink_d1", 32'(seen[1]), 32'hEF);

        // Invalid BCD shows a dash, then clear mid-frame
        colon_on   = 1'b0;
        blink_mask = 6'd0;
        HourL      = 4'hC;
        sync_fd();
        frame();
        check_eq("dash_d1", 32'(seen[1]), 32'h40);
        repeat (10) step(1'b0);
        step(1'b1);
        step(1'b0);
        check_eq("cr_mid_dig", 32'(dig), 32'b000001);
        check_eq("cr_mid_seg", 32'(seg), 32'h00);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0: HourH = 4'($urandom_range(0, 15));
                    1: HourL = 4'($urandom_range(0, 15));
                    2: MinH  = 4'($urandom_range(0, 15));
                    3: MinL  = 4'($urandom_range(0, 15));
                    4: SecH  = 4'($urandom_range(0, 15));
                    default: SecL = 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 9) == 0) blink_mask  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) blink_phase = ~blink_phase;
            if ($urandom_range(0, 7) == 0) colon_on    = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
